// File: rtl/mem_stage_wait.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_wait
// Description : MEM pipeline stage. It holds a word-addressed data memory
//               with WAIT_CYCLES wait states. An IDLE/BUSY FSM raises `freeze`
//               to stall upstream stages while an access is in flight. The
//               module also holds the MEM/WB pipeline register and provides
//               combinational forwarding information.
// Ports       : clk, rst (async, active-low)
//               EX/MEM inputs : wb_dest_in, store_value, alu_result_in,
//                               mem_w_en_in, mem_r_en_in, wb_en_in
//               outputs       : freeze (stall upstream)
//                               wb_dest, mem_data, alu_result, mem_r_en,
//                               wb_en (registered, to WB)
//                               fwd_dest, fwd_wb_en (combinational)
// Options     : MEM_BYTE_ACCESS_EN adds input mem_byte_in. When this input
//               is set, accesses use a single byte lane.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_wait #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 4,
    parameter int          REG_ADDR_W  = 4,
    parameter int unsigned BASE_ADDR   = 1024
) (
`ifdef MEM_BYTE_ACCESS_EN
    input  logic                  mem_byte_in,
`endif
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wb_dest_in,
    input  logic [DATA_W-1:0]     store_value,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic                  mem_w_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  wb_en_in,
    output logic                  freeze,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic [DATA_W-1:0]     mem_data,
    output logic [DATA_W-1:0]     alu_result,
    output logic                  mem_r_en,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] fwd_dest,
    output logic                  fwd_wb_en
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] addr_off;
    logic [IDX_W-1:0]  idx;
    logic              unused_addr_bits;
    logic              req;
    logic              is_store;
    logic              is_load;
    logic              stall;
    logic              commit;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] wr_word;

    logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0]     mem_data_q, mem_data_d;
    logic [DATA_W-1:0]     alu_result_q, alu_result_d;
    logic                  mem_r_en_q, mem_r_en_d;
    logic                  wb_en_q, wb_en_d;

    // Address decode. Bits above the index and the byte offset are dropped,
    // so addresses outside the memory wrap modulo DEPTH.
    assign addr_off         = alu_result_in - DATA_W'(BASE_ADDR);
    assign idx              = addr_off[IDX_W+1:2];
    assign unused_addr_bits = ^{addr_off[DATA_W-1:IDX_W+2], addr_off[1:0]};

    // A request with both enables set is treated as a store.
    assign req      = mem_r_en_in | mem_w_en_in;
    assign is_store = mem_w_en_in;
    assign is_load  = mem_r_en_in & ~mem_w_en_in;

    assign rd_word = mem[idx];

    always_comb begin
        rd_data = rd_word;
        wr_word = store_value;
`ifdef MEM_BYTE_ACCESS_EN
        if (mem_byte_in) begin
            // The byte write is a read-modify-write of the addressed word.
            rd_data      = '0;
            rd_data[7:0] = rd_word[{alu_result_in[1:0], 3'b000} +: 8];
            wr_word      = rd_word;
            wr_word[{alu_result_in[1:0], 3'b000} +: 8] = store_value[7:0];
        end
`endif
    end

    generate
        if (WAIT_CYCLES > 0) begin : g_fsm
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // freeze is asserted in the request cycle itself and stays high
            // until the counter expires. That gives WAIT_CYCLES stall cycles
            // followed by one completion cycle.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                stall   = 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (req) begin
                            stall   = 1'b1;
                            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                            state_d = S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        if (cnt_q != '0) begin
                            stall = 1'b1;
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else begin : g_no_fsm
            assign stall = 1'b0;
        end
    endgenerate

    // Gating with rst drops freeze as soon as reset is applied, even when a
    // request is still present on the inputs.
    assign freeze = rst & stall;
    assign commit = rst & ~stall;

    // A store commits only at the completion edge. A reset in mid-access
    // therefore never leaves a partial write.
    always_ff @(posedge clk) begin
        if (commit && is_store) begin
            mem[idx] <= wr_word;
        end
    end

    // While frozen, the MEM/WB register loads a bubble. The data fields hold.
    always_comb begin
        wb_dest_d    = wb_dest_q;
        alu_result_d = alu_result_q;
        mem_data_d   = mem_data_q;
        mem_r_en_d   = 1'b0;
        wb_en_d      = 1'b0;
        if (!stall) begin
            wb_dest_d    = wb_dest_in;
            alu_result_d = alu_result_in;
            mem_r_en_d   = is_load;
            wb_en_d      = wb_en_in;
            if (is_load) begin
                mem_data_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_dest_q    <= '0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            mem_r_en_q   <= 1'b0;
            wb_en_q      <= 1'b0;
        end else begin
            wb_dest_q    <= wb_dest_d;
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
            mem_r_en_q   <= mem_r_en_d;
            wb_en_q      <= wb_en_d;
        end
    end

    assign wb_dest    = wb_dest_q;
    assign alu_result = alu_result_q;
    assign mem_data   = mem_data_q;
    assign mem_r_en   = mem_r_en_q;
    assign wb_en      = wb_en_q;

    assign fwd_dest   = wb_dest_in;
    assign fwd_wb_en  = wb_en_in;

endmodule
`default_nettype wire
